// File: rtl/conv_window_gen.sv
// Zero-padded 3x3 sliding-window generator (stride 1, pad 1) feeding the conv stage.
// Optional macro WIN_STRIDE2_EN: emit only windows with even centre row and column.
module conv_window_gen #(
  parameter int CH    = 16,
  parameter int BW    = 8,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CH*BW-1:0]           in_pixel,
  output logic                       win_valid,
  output logic [CH*9*BW-1:0]         win_data,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       frame_done
);

  localparam int PW = CH * BW;
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_EOL, S_FLUSH, S_DONE} state_t;

  state_t                  r_state, w_next;
  logic [RW-1:0]           r_row;
  logic [CW-1:0]           r_col;
  logic                    r_done_pulse;
  logic [PW-1:0]           r_lb0 [IMG_W];
  logic [PW-1:0]           r_lb1 [IMG_W];
  logic [2:0][PW-1:0]      r_cl, r_cm;
  logic                    r_win_valid;
  logic [CH*9*BW-1:0]      r_win_data;
  logic [RW-1:0]           r_win_row;
  logic [CW-1:0]           r_win_col;

  logic                    w_accept, w_last_col, w_start_ok, w_shift;
  logic                    w_emit, w_emit_out;
  logic [CW-1:0]           w_rd;
  logic [RW-1:0]           w_cr;
  logic [CW-1:0]           w_cc;
  logic [2:0][PW-1:0]      w_cn;
  logic [2:0][2:0][PW-1:0] w_cols;
  logic [2:0]              w_rok, w_cok;
  logic [CH*9*BW-1:0]      w_win;

  assign w_accept   = (r_state == S_RUN) && in_valid;
  assign w_last_col = (r_col == CW'(IMG_W - 1));
  assign w_start_ok = start && ((r_state == S_IDLE) || ((r_state == S_DONE) && !r_done_pulse));
  assign w_shift    = w_accept || (r_state == S_EOL) || (r_state == S_FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_RUN;
      S_RUN:   if (w_accept && w_last_col && (r_row != '0)) w_next = S_EOL;
      S_EOL:   w_next = (r_row == RW'(IMG_H - 1)) ? S_FLUSH : S_RUN;
      S_FLUSH: if (w_last_col) w_next = S_DONE;
      S_DONE:  if (w_start_ok) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (r_state == S_RUN);
    frame_done = r_done_pulse;
  end

  // Row 0 wraps straight into row 1; later rows advance in EOL so EOL still sees its own row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row        <= '0;
      r_col        <= '0;
      r_done_pulse <= 1'b0;
    end else begin
      r_done_pulse <= (w_next == S_DONE) && (r_state != S_DONE);
      if (w_start_ok) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_accept) begin
        if (w_last_col) begin
          r_col <= '0;
          if (r_row == '0) r_row <= RW'(1);
        end else begin
          r_col <= r_col + 1'b1;
        end
      end else if (r_state == S_EOL) begin
        if (r_row != RW'(IMG_H - 1)) r_row <= r_row + 1'b1;
      end else if (r_state == S_FLUSH) begin
        r_col <= w_last_col ? '0 : r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb0[r_col] <= in_pixel;
    end
  end

  // EOL prefetches column 0 so FLUSH always has its right-hand column one read ahead.
  always_comb begin
    case (r_state)
      S_EOL:   w_rd = '0;
      S_FLUSH: w_rd = w_last_col ? '0 : r_col + 1'b1;
      default: w_rd = r_col;
    endcase
    w_cn[0] = r_lb1[w_rd];
    w_cn[1] = r_lb0[w_rd];
    w_cn[2] = (r_state == S_RUN) ? in_pixel : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cl <= '0;
      r_cm <= '0;
    end else if (w_shift) begin
      r_cl <= r_cm;
      r_cm <= w_cn;
    end
  end

  always_comb begin
    w_emit = 1'b0;
    w_cr   = r_row - 1'b1;
    w_cc   = r_col - 1'b1;
    case (r_state)
      S_RUN:   w_emit = w_accept && (r_row != '0) && (r_col != '0);
      S_EOL: begin
        w_emit = 1'b1;
        w_cc   = CW'(IMG_W - 1);
      end
      S_FLUSH: begin
        w_emit = 1'b1;
        w_cr   = RW'(IMG_H - 1);
        w_cc   = r_col;
      end
      default: w_emit = 1'b0;
    endcase
  end

`ifdef WIN_STRIDE2_EN
  assign w_emit_out = w_emit && !w_cr[0] && !w_cc[0];
`else
  assign w_emit_out = w_emit;
`endif

  // Padding is decided purely from the centre position, so stale buffer data is always masked.
  always_comb begin
    w_rok  = {(w_cr != RW'(IMG_H - 1)), 1'b1, (w_cr != '0)};
    w_cok  = {(w_cc != CW'(IMG_W - 1)), 1'b1, (w_cc != '0)};
    w_cols = {w_cn, r_cm, r_cl};
    w_win  = '0;
    for (int unsigned c = 0; c < CH; c++)
      for (int unsigned ky = 0; ky < 3; ky++)
        for (int unsigned kx = 0; kx < 3; kx++)
          if (w_rok[ky] && w_cok[kx])
            w_win[(c*9 + ky*3 + kx)*BW +: BW] = w_cols[kx][ky][c*BW +: BW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_valid <= 1'b0;
      r_win_data  <= '0;
      r_win_row   <= '0;
      r_win_col   <= '0;
    end else begin
      r_win_valid <= w_emit_out;
      if (w_emit_out) begin
        r_win_data <= w_win;
        r_win_row  <= w_cr;
        r_win_col  <= w_cc;
      end
    end
  end

  assign win_valid = r_win_valid;
  assign win_data  = r_win_data;
  assign win_row   = r_win_row;
  assign win_col   = r_win_col;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on a 4x4, 16-channel frame.
module tb_conv_window_gen;

  localparam int CH  = 16;
  localparam int BW  = 8;
  localparam int N   = 4;
  localparam int PW  = CH * BW;
  localparam int WDW = CH * 9 * BW;
`ifdef WIN_STRIDE2_EN
  localparam int EXP_WIN = 4;
`else
  localparam int EXP_WIN = 16;
`endif

  logic           clk = 1'b0;
  logic           rst_n, start, in_valid, in_ready, win_valid, frame_done;
  logic [PW-1:0]  in_pixel;
  logic [WDW-1:0] win_data;
  logic [1:0]     win_row, win_col;

  typedef struct {
    logic [1:0]     row;
    logic [1:0]     col;
    logic [WDW-1:0] data;
  } exp_t;

  exp_t           sb[$];
  logic [PW-1:0]  img [N][N];
  logic [WDW-1:0] cap [N*N];
  int             tests = 0;
  int             fails = 0;

  conv_window_gen #(.CH(CH), .BW(BW), .IMG_W(N), .IMG_H(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_pixel(in_pixel), .win_valid(win_valid),
    .win_data(win_data), .win_row(win_row), .win_col(win_col),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pix(int base, int r, int c);
    logic [PW-1:0] v;
    for (int ch = 0; ch < CH; ch++) v[ch*BW +: BW] = 8'(base + r*N + c + 1 + 16*ch);
    return v;
  endfunction

  function automatic logic [WDW-1:0] ref_win(int r, int c);
    logic [WDW-1:0] w = '0;
    for (int ch = 0; ch < CH; ch++)
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++)
          if (r+dy >= 0 && r+dy < N && c+dx >= 0 && c+dx < N)
            w[(ch*9 + (dy+1)*3 + (dx+1))*BW +: BW] = img[r+dy][c+dx][ch*BW +: BW];
    return w;
  endfunction

  function automatic bit emitted(int r, int c);
`ifdef WIN_STRIDE2_EN
    return (r % 2 == 0) && (c % 2 == 0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic run_frame(input string name, input int base, input bit gaps,
                           input int start_at, input int abort_at);
    int   idx = 0, nwin = 0, nlow = 0;
    bit   seen_done = 0, start_sent = 0;
    exp_t e;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) img[r][c] = pix(base, r, c);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (emitted(r, c)) begin
          e.row = 2'(r); e.col = 2'(c); e.data = ref_win(r, c);
          sb.push_back(e);
        end
    for (int i = 0; i < N*N; i++) cap[i] = '0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (win_valid) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL %s unexpected window at (%0d,%0d)", name, win_row, win_col);
        end else begin
          e = sb.pop_front();
          if (win_row !== e.row || win_col !== e.col || win_data !== e.data) begin
            fails++;
            $display("FAIL %s window got (%0d,%0d) %h want (%0d,%0d) %h", name,
                     win_row, win_col, win_data[71:0], e.row, e.col, e.data[71:0]);
          end
        end
        cap[win_row*N + win_col] = win_data;
        nwin++;
      end
      if (frame_done) begin
        seen_done = 1;
        break;
      end
      if (idx > 0 && !in_ready) nlow++;
      if (abort_at >= 0 && idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, win_valid, frame_done, win_row, win_col} !== '0 || win_data !== '0) begin
          fails++;
          $display("FAIL %s async reset outputs got %b/%b/%b/%0d/%0d want all 0", name,
                   in_ready, win_valid, frame_done, win_row, win_col);
        end
        in_valid = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          tests++;
          if (in_ready !== 1'b0 || frame_done !== 1'b0 || win_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s idle after reset got rdy=%b done=%b wv=%b want 0", name,
                     in_ready, frame_done, win_valid);
          end
        end
        return;
      end
      start = (idx == start_at) && !start_sent;
      if (start) start_sent = 1;
      in_valid = (idx < N*N) && (!gaps || cyc[0]);
      in_pixel = (idx < N*N) ? pix(base, idx / N, idx % N) : '0;
      if (in_valid && in_ready) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    tests++;
    if (!seen_done) begin
      fails++;
      $display("FAIL %s frame_done timeout got none want pulse", name);
    end
    tests++;
    if (sb.size() != 0 || nwin != EXP_WIN) begin
      fails++;
      $display("FAIL %s window count got %0d (left %0d) want %0d", name, nwin, sb.size(), EXP_WIN);
    end
    tests++;
    if (nlow != 7 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s in_ready low cycles got %0d want 7", name, nlow);
    end
    repeat (4) begin
      @(negedge clk);
      tests++;
      if (frame_done !== 1'b0 || win_valid !== 1'b0 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s after done got done=%b wv=%b rdy=%b want 0", name,
                 frame_done, win_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_pixel = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({in_ready, win_valid, frame_done, win_row, win_col} !== '0 || win_data !== '0) begin
      fails++;
      $display("FAIL reset outputs got %b/%b/%b/%0d/%0d want all 0",
               in_ready, win_valid, frame_done, win_row, win_col);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_taps(input string name, input int r, input int c, input logic [71:0] want);
    logic [WDW-1:0] w;
    w = cap[r*N + c];
    tests++;
    if (w[71:0] !== want) begin
      fails++;
      $display("FAIL %s taps (%0d,%0d) got %h want %h", name, r, c, w[71:0], want);
    end
  endtask

  task automatic test_basic();
    run_frame("basic", 0, 1'b0, -1, -1);
    check_taps("basic", 0, 0, {8'd6, 8'd5, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0});
`ifdef WIN_STRIDE2_EN
    check_taps("basic", 2, 2, {8'd16, 8'd15, 8'd14, 8'd12, 8'd11, 8'd10, 8'd8, 8'd7, 8'd6});
`else
    check_taps("basic", 1, 1, {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1});
    check_taps("basic", 3, 3, {8'd0, 8'd0, 8'd0, 8'd0, 8'd16, 8'd15, 8'd0, 8'd12, 8'd11});
`endif
  endtask

  task automatic test_gaps();
    run_frame("gaps", 0, 1'b1, -1, -1);
  endtask

  task automatic test_back_to_back();
    run_frame("b2b", 100, 1'b0, -1, -1);
  endtask

  task automatic test_start_in_run();
    run_frame("start_run", 30, 1'b0, 6, -1);
  endtask

  task automatic test_midframe_reset();
    run_frame("abort", 70, 1'b0, -1, 9);
    run_frame("after_abort", 50, 1'b0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_start_in_run();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Upstream feeder for the 3x3 convolution top. Accepts a raster-order stream of multi-channel input pixels and builds zero-padded 3x3 sliding windows (stride 1, pad 1) with two line buffers and a 3x3 register window. Each window is one flattened activation word, presented with a valid pulse directly on the conv stage's activation input. One window is produced per output pixel, so an H x W frame gives H*W windows.

Parameters:
CH, 16, channels per pixel (matches conv stage IN_CHANNEL)
BW, 8, bits per activation (matches BITWIDTH)
IMG_W, 28, frame width in pixels, >= 3
IMG_H, 28, frame height in pixels, >= 3

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle frame start, honoured only in IDLE or DONE
in_valid  input  1  pixel valid
in_ready  output  1  pixel accept, transfer when in_valid && in_ready
in_pixel  input  CH*BW  channel c at [c*BW +: BW]
win_valid  output  1  win_data valid this cycle, no backpressure
win_data  output  CH*9*BW  channel c, tap k=ky*3+kx at [(c*9+k)*BW +: BW]; ky/kx 0..2 = row/col offsets -1..+1
win_row  output  clog2(IMG_H)  centre row of current window
win_col  output  clog2(IMG_W)  centre column of current window
frame_done  output  1  one-cycle pulse after the last window

Behaviour:
- Clock and reset: one clock clk. rst_n is asynchronous and active-low. Assertion puts the FSM in IDLE and clears counters, the window registers and all outputs: in_ready=0, win_valid=0, win_data=0, win_row=0, win_col=0, frame_done=0. Line-buffer RAM needs no clearing.
- FSM states:
  - IDLE: in_ready=0. On start, clear counters and go to RUN.
  - RUN: in_ready=1. Accepts pixel (R,C) in raster order.
  - EOL: one cycle, in_ready=0.
  - FLUSH: in_ready=0, one window per cycle.
  - DONE: in_ready=0. frame_done=1 for exactly the cycle of entry, then hold.
- RUN pixel handling:
  - Accepting (R,C) with R>=1 and C>=1 yields the window centred (R-1,C-1).
  - If C==IMG_W-1 and R>=1, go to EOL, which yields the window centred (R-1,IMG_W-1).
  - Accepting (IMG_H-1,IMG_W-1) goes to EOL, then to FLUSH.
- FLUSH yields windows centred (IMG_H-1, 0..IMG_W-1), one per cycle, then goes to DONE.
- Latency: a window is registered, with win_valid high, exactly 1 cycle after its triggering acceptance or EOL/FLUSH cycle.
- Padding: taps with centre row+dy outside 0..IMG_H-1, or col+dx outside 0..IMG_W-1, are forced to 0 by masking. Stale line-buffer or window contents never leak into a window.
- Gaps: in_valid low in RUN stalls everything with no output. win_valid=0 in any cycle with no window.
- Counters: column wraps IMG_W-1 -> 0 and increments the row. The row counter stops at IMG_H-1.
- Line buffers: two IMG_W-deep CH*BW-wide arrays, written with the accepted pixel and read at the same column address. Writes complete before the next cycle's read.
- start while in RUN/EOL/FLUSH is ignored. start in the same cycle as the DONE entry is ignored, so frame_done is still pulsed; start in a later DONE cycle is honoured.
- A reset mid-frame aborts the frame with no frame_done. The next start begins a fresh frame.

Optional Feature:
WIN_STRIDE2_EN:
- Defined: win_valid is asserted only for windows whose centre row and column are both even, giving ceil(IMG_H/2)*ceil(IMG_W/2) windows. Internal timing, in_ready and frame_done timing are unchanged. Non-emitted cycles hold win_valid=0.
- Undefined: all H*W windows are emitted.

Test Plan:
- CH=1, BW=8, IMG_W=IMG_H=4, pixel=R*4+C+1, in_valid held high. Window (0,0) taps = [0,0,0,0,1,2,0,5,6]; window (1,1) = [1,2,3,5,6,7,9,10,11]; window (3,3) = [11,12,0,15,16,0,0,0,0]; exactly 16 win_valid pulses in raster centre order; frame_done one cycle after the last window.
- Same frame with in_valid toggling every other cycle -> identical window sequence and data. in_ready=0 in each EOL cycle and for all 4 FLUSH cycles.
- CH=16, second frame started in DONE with different data -> no data from frame 1 appears in any tap; top-row taps are 0.
- rst_n pulsed low mid-frame at pixel (2,1) -> all outputs 0 asynchronously, FSM IDLE, no frame_done. A new start then produces the correct 16 windows.
- start pulsed during RUN -> ignored; counters and window sequence unaffected.
- WIN_STRIDE2_EN defined, 4x4 frame -> exactly 4 windows, centres (0,0), (0,2), (2,0), (2,2). Window (2,2) taps = [6,7,8,10,11,12,14,15,16].
